// File: rtl/vga_pkg.sv
// Shared types, default 800x480 timing and width helpers for the VGA stream timing block.
package vga_pkg;

    typedef enum logic [1:0] {
        SEEK   = 2'd0,
        ARMED  = 2'd1,
        LOCKED = 2'd2
    } lock_state_t;

    localparam int DEF_HDISP  = 800;
    localparam int DEF_VDISP  = 480;
    localparam int DEF_HFP    = 40;
    localparam int DEF_HPULSE = 48;
    localparam int DEF_HBP    = 40;
    localparam int DEF_VFP    = 13;
    localparam int DEF_VPULSE = 3;
    localparam int DEF_VBP    = 29;
    localparam int DEF_PIX_W  = 24;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vga_stream_timing_if.sv
// Valid/ready pixel stream with start-of-frame marker.
interface vga_stream_timing_if #(
    parameter int PIX_W = 24
) ();

    logic             pix_valid;
    logic             pix_sof;
    logic [PIX_W-1:0] pix_data;
    logic             pix_ready;

    modport master (
        output pix_valid, pix_sof, pix_data,
        input  pix_ready
    );

    modport slave (
        input  pix_valid, pix_sof, pix_data,
        output pix_ready
    );

endinterface

// File: rtl/vga_raster_cnt.sv
// Horizontal/vertical raster counters with active, sync and first-pixel decodes.
module vga_raster_cnt
    import vga_pkg::*;
#(
    parameter int HDISP  = DEF_HDISP,
    parameter int VDISP  = DEF_VDISP,
    parameter int HFP    = DEF_HFP,
    parameter int HPULSE = DEF_HPULSE,
    parameter int HBP    = DEF_HBP,
    parameter int VFP    = DEF_VFP,
    parameter int VPULSE = DEF_VPULSE,
    parameter int VBP    = DEF_VBP
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      active,
    output logic                      hsync,
    output logic                      vsync,
    output logic                      first,
    output logic [cnt_w(HDISP)-1:0]   x,
    output logic [cnt_w(VDISP)-1:0]   y
);

    localparam int HT = HDISP + HFP + HPULSE + HBP;
    localparam int VT = VDISP + VFP + VPULSE + VBP;
    localparam int HW = cnt_w(HT);
    localparam int VW = cnt_w(VT);
    localparam int XW = cnt_w(HDISP);
    localparam int YW = cnt_w(VDISP);

    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [VW-1:0] vcnt_q, vcnt_d;
    logic [HW-1:0] hoff;
    logic [VW-1:0] voff;

    always_comb begin
        hcnt_d = hcnt_q + HW'(1);
        vcnt_d = vcnt_q;
        if (hcnt_q == HW'(HT - 1)) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == VW'(VT - 1)) ? '0 : vcnt_q + VW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
        end
    end

    // Active region sits at the end of each line and frame.
    assign active = (hcnt_q >= HW'(HT - HDISP)) && (vcnt_q >= VW'(VT - VDISP));
    assign first  = (hcnt_q == HW'(HT - HDISP)) && (vcnt_q == VW'(VT - VDISP));
    assign hsync  = (hcnt_q >= HW'(HFP)) && (hcnt_q < HW'(HFP + HPULSE));
    assign vsync  = (vcnt_q >= VW'(VFP)) && (vcnt_q < VW'(VFP + VPULSE));
    assign hoff   = hcnt_q - HW'(HT - HDISP);
    assign voff   = vcnt_q - VW'(VT - VDISP);
    assign x      = XW'(hoff);
    assign y      = YW'(voff);

endmodule

// File: rtl/vga_stream_timing.sv
// VGA timing generator that locks a valid/ready pixel stream to the raster.
// Define VGA_STREAM_STATS_EN to add the saturating underflow_cnt port.
module vga_stream_timing
    import vga_pkg::*;
#(
    parameter int               HDISP    = DEF_HDISP,
    parameter int               VDISP    = DEF_VDISP,
    parameter int               HFP      = DEF_HFP,
    parameter int               HPULSE   = DEF_HPULSE,
    parameter int               HBP      = DEF_HBP,
    parameter int               VFP      = DEF_VFP,
    parameter int               VPULSE   = DEF_VPULSE,
    parameter int               VBP      = DEF_VBP,
    parameter int               PIX_W    = DEF_PIX_W,
    parameter logic             HS_POL   = 1'b0,
    parameter logic             VS_POL   = 1'b0,
    parameter logic [PIX_W-1:0] BG_COLOR = '0
) (
    input  logic                     pixel_clk,
    input  logic                     pixel_rst,
    vga_stream_timing_if.slave       pix,
    output logic                     vga_clk,
    output logic                     vga_hs,
    output logic                     vga_vs,
    output logic                     vga_blank,
    output logic [PIX_W-1:0]         vga_rgb,
    output logic [cnt_w(HDISP)-1:0]  pos_x,
    output logic [cnt_w(VDISP)-1:0]  pos_y,
    output logic                     frame_start,
    output logic                     locked,
    output logic                     underflow
`ifdef VGA_STREAM_STATS_EN
    ,
    output logic [15:0]              underflow_cnt
`endif
);

    localparam int XW = cnt_w(HDISP);
    localparam int YW = cnt_w(VDISP);

    logic          active, hsync, vsync, first;
    logic [XW-1:0] x;
    logic [YW-1:0] y;

    lock_state_t      state_q, state_d;
    logic             hs_q, hs_d, vs_q, vs_d, blank_q, blank_d;
    logic [PIX_W-1:0] rgb_q, rgb_d;
    logic [XW-1:0]    pos_x_q, pos_x_d;
    logic [YW-1:0]    pos_y_q, pos_y_d;
    logic             fs_q, fs_d, uf_q, uf_d;
    logic             ready;
    logic             take_sof;

    vga_raster_cnt #(
        .HDISP(HDISP), .VDISP(VDISP),
        .HFP(HFP), .HPULSE(HPULSE), .HBP(HBP),
        .VFP(VFP), .VPULSE(VPULSE), .VBP(VBP)
    ) u_raster (
        .clk(pixel_clk), .rst(pixel_rst),
        .active(active), .hsync(hsync), .vsync(vsync),
        .first(first), .x(x), .y(y)
    );

    assign take_sof = pix.pix_valid && pix.pix_sof;

    always_comb begin
        state_d = state_q;
        rgb_d   = active ? BG_COLOR : '0;
        uf_d    = 1'b0;
        ready   = 1'b0;
        unique case (state_q)
            SEEK: begin
                ready = !take_sof;
                if (take_sof) state_d = ARMED;
            end
            ARMED: begin
                ready = first;
                if (first) begin
                    if (take_sof) begin
                        rgb_d   = pix.pix_data;
                        state_d = LOCKED;
                    end else begin
                        state_d = SEEK;
                    end
                end
            end
            LOCKED: begin
                ready = active;
                // sof must coincide exactly with the first pixel of the frame
                if (active) begin
                    if (pix.pix_valid && (pix.pix_sof == first)) begin
                        rgb_d = pix.pix_data;
                    end else begin
                        uf_d    = 1'b1;
                        state_d = SEEK;
                    end
                end
            end
            default: state_d = SEEK;
        endcase
        if (pixel_rst) ready = 1'b0;
    end

    always_comb begin
        hs_d    = hsync ? HS_POL : !HS_POL;
        vs_d    = vsync ? VS_POL : !VS_POL;
        blank_d = active;
        pos_x_d = active ? x : '0;
        pos_y_d = active ? y : '0;
        fs_d    = first;
    end

    always_ff @(posedge pixel_clk) begin
        if (pixel_rst) begin
            state_q <= SEEK;
            hs_q    <= !HS_POL;
            vs_q    <= !VS_POL;
            blank_q <= 1'b0;
            rgb_q   <= '0;
            pos_x_q <= '0;
            pos_y_q <= '0;
            fs_q    <= 1'b0;
            uf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            blank_q <= blank_d;
            rgb_q   <= rgb_d;
            pos_x_q <= pos_x_d;
            pos_y_q <= pos_y_d;
            fs_q    <= fs_d;
            uf_q    <= uf_d;
        end
    end

`ifdef VGA_STREAM_STATS_EN
    logic [15:0] ucnt_q, ucnt_d;

    always_comb begin
        ucnt_d = ucnt_q;
        if (uf_d && (ucnt_q != 16'hFFFF)) ucnt_d = ucnt_q + 16'd1;
    end

    always_ff @(posedge pixel_clk) begin
        if (pixel_rst) ucnt_q <= '0;
        else           ucnt_q <= ucnt_d;
    end

    assign underflow_cnt = ucnt_q;
`endif

    assign pix.pix_ready = ready;
    assign vga_clk       = pixel_clk;
    assign vga_hs        = hs_q;
    assign vga_vs        = vs_q;
    assign vga_blank     = blank_q;
    assign vga_rgb       = rgb_q;
    assign pos_x         = pos_x_q;
    assign pos_y         = pos_y_q;
    assign frame_start   = fs_q;
    assign locked        = (state_q == LOCKED);
    assign underflow     = uf_q;

endmodule

// File: tb/tb_vga_stream_timing.sv
// Randomised stream bench for vga_stream_timing against a raster/frame-index model.
module tb_vga_stream_timing;

    localparam int HD = 4, VD = 2, HT = 7, VT = 5, PW = 8;
    localparam logic [7:0] BG = 8'hAA;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic vga_clk, vga_hs, vga_vs, vga_blank, frame_start, locked, underflow;
    logic [7:0] vga_rgb;
    logic [1:0] pos_x;
    logic [0:0] pos_y;
`ifdef VGA_STREAM_STATS_EN
    logic [15:0] underflow_cnt;
`endif

    vga_stream_timing_if #(.PIX_W(PW)) sif ();

    vga_stream_timing #(
        .HDISP(HD), .VDISP(VD),
        .HFP(1), .HPULSE(1), .HBP(1),
        .VFP(1), .VPULSE(1), .VBP(1),
        .PIX_W(PW), .HS_POL(1'b0), .VS_POL(1'b0), .BG_COLOR(BG)
    ) dut (
        .pixel_clk(clk), .pixel_rst(rst), .pix(sif),
        .vga_clk(vga_clk), .vga_hs(vga_hs), .vga_vs(vga_vs),
        .vga_blank(vga_blank), .vga_rgb(vga_rgb),
        .pos_x(pos_x), .pos_y(pos_y),
        .frame_start(frame_start), .locked(locked), .underflow(underflow)
`ifdef VGA_STREAM_STATS_EN
        , .underflow_cnt(underflow_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;

    // model: t = cycles since reset, synced/armed = lock progress
    int t = 0;
    bit synced = 0, armed = 0;
    int ucnt = 0;
    bit e_rdy, e_hs, e_vs, e_blank, e_fs, e_uf;
    logic [7:0] e_rgb;
    int e_px, e_py;

    // source
    int nxt = 0, pv = 0, ps = 0;
    bit pend = 0, cur_s = 0, f_drop = 0, f_sof = 0;
    logic [7:0] cur_d = 8'h00;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            if (n_bad <= 20)
                $display("FAIL %s @%0t: got %0h want %0h", nm, $time, a, e);
        end
    endtask

    task automatic drive();
        if (!pend && ($urandom_range(99) < pv)) begin
            pend  = 1;
            cur_d = 8'(nxt);
            cur_s = (nxt % 8 == 0) || ($urandom_range(99) < ps);
        end
        sif.pix_valid = pend && !f_drop;
        sif.pix_sof   = cur_s || f_sof;
        sif.pix_data  = cur_d;
    endtask

    task automatic cycle();
        int h, v, idx;
        bit act, vl, sf, acc;
        logic [7:0] d;
        drive();
        #1;
        vl = sif.pix_valid; sf = sif.pix_sof; d = sif.pix_data;
        h = t % HT;
        v = (t / HT) % VT;
        act = (h >= HT - HD) && (v >= VT - VD);
        idx = act ? (v - (VT - VD)) * HD + (h - (HT - HD)) : -1;
        e_rgb = act ? BG : 8'h00;
        e_uf = 0;
        if (rst) begin
            e_rdy = 0; e_hs = 1; e_vs = 1; e_blank = 0; e_rgb = 8'h00;
            e_px = 0; e_py = 0; e_fs = 0;
            synced = 0; armed = 0; ucnt = 0; t = 0;
        end else begin
            if (synced) begin
                e_rdy = act;
                if (act) begin
                    if (vl && (sf == (idx == 0))) e_rgb = d;
                    else begin
                        e_uf = 1; synced = 0;
                        if (ucnt < 65535) ucnt++;
                    end
                end
            end else if (armed) begin
                e_rdy = (idx == 0);
                if (idx == 0) begin
                    armed = 0;
                    if (vl && sf) begin synced = 1; e_rgb = d; end
                end
            end else begin
                e_rdy = !(vl && sf);
                if (vl && sf) armed = 1;
            end
            e_hs = (h != 1);
            e_vs = (v != 1);
            e_blank = act;
            e_px = act ? idx % HD : 0;
            e_py = act ? idx / HD : 0;
            e_fs = (idx == 0);
            t++;
        end
        chk("pix_ready", 32'(sif.pix_ready), 32'(e_rdy));
        acc = vl && e_rdy;
        @(posedge clk);
        #1;
        chk("vga_hs", 32'(vga_hs), 32'(e_hs));
        chk("vga_vs", 32'(vga_vs), 32'(e_vs));
        chk("vga_blank", 32'(vga_blank), 32'(e_blank));
        chk("vga_rgb", 32'(vga_rgb), 32'(e_rgb));
        chk("pos_x", 32'(pos_x), 32'(e_px));
        chk("pos_y", 32'(pos_y), 32'(e_py));
        chk("frame_start", 32'(frame_start), 32'(e_fs));
        chk("underflow", 32'(underflow), 32'(e_uf));
        chk("locked", 32'(locked), 32'(synced));
`ifdef VGA_STREAM_STATS_EN
        chk("underflow_cnt", 32'(underflow_cnt), 32'(ucnt));
`endif
        if (acc) begin pend = 0; nxt++; end
        f_drop = 0;
        f_sof = 0;
        @(negedge clk);
    endtask

    // wait for lock, then pull valid low on frame pixel 5
    task automatic force_drop();
        bit done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            if (synced && (t % HT == 4) && ((t / HT) % VT == 4)) begin
                f_drop = 1;
                done = 1;
            end
            cycle();
        end
        chk("drop_found", 32'(done), 32'd1);
    endtask

    initial begin
        int hs_lo, vs_lo, bl, bg_n, fs_n, cap;
        bit done;
        sif.pix_valid = 0; sif.pix_sof = 0; sif.pix_data = '0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) cycle();
        chk("rst_hs", 32'(vga_hs), 32'd1);
        chk("rst_blank", 32'(vga_blank), 32'd0);
        rst = 0;

        // idle raster, no stream
        hs_lo = 0; vs_lo = 0; bl = 0; bg_n = 0;
        for (int i = 0; i < 35; i++) begin
            cycle();
            if (!vga_hs) hs_lo++;
            if (!vga_vs) vs_lo++;
            if (vga_blank) bl++;
            if (vga_blank && vga_rgb == 8'hAA) bg_n++;
        end
        chk("idle_hs_low", 32'(hs_lo), 32'd5);
        chk("idle_vs_low", 32'(vs_lo), 32'd7);
        chk("idle_blank", 32'(bl), 32'd8);
        chk("idle_bg", 32'(bg_n), 32'd8);
        chk("idle_unlocked", 32'(locked), 32'd0);

        // continuous stream 0,1,2,...
        pv = 100; nxt = 0; cap = 0;
        for (int i = 0; i < 70; i++) begin
            cycle();
            if (vga_blank && locked && cap < 8) begin
                chk("lock_seq", 32'(vga_rgb), 32'(cap));
                cap++;
            end
        end
        chk("lock_seq_len", 32'(cap), 32'd8);
        fs_n = 0;
        for (int i = 0; i < 35; i++) begin
            cycle();
            if (frame_start) fs_n++;
        end
        chk("fs_per_frame", 32'(fs_n), 32'd1);
        chk("locked_stream", 32'(locked), 32'd1);

        // underflow on pixel 5
        force_drop();
        chk("drop_uf", 32'(underflow), 32'd1);
        chk("drop_bg5", 32'(vga_rgb), 32'hAA);
        cycle();
        chk("drop_bg6", 32'(vga_rgb), 32'hAA);
        chk("drop_unlocked", 32'(locked), 32'd0);
        for (int i = 0; i < 70; i++) cycle();
        chk("drop_relock", 32'(locked), 32'd1);

        // stray sof on pixel 2
        done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            if (synced && (t % HT == 5) && ((t / HT) % VT == 3)) begin
                f_sof = 1;
                done = 1;
            end
            cycle();
        end
        chk("sof_found", 32'(done), 32'd1);
        chk("sof_uf", 32'(underflow), 32'd1);
        chk("sof_bg", 32'(vga_rgb), 32'hAA);
        for (int i = 0; i < 70; i++) cycle();
        chk("sof_relock", 32'(locked), 32'd1);

        // reset mid active line
        done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            if ((t % HT == 4) && ((t / HT) % VT == 3)) done = 1;
            else cycle();
        end
        chk("rst_found", 32'(done), 32'd1);
        rst = 1;
        cycle();
        rst = 0;
        chk("mid_rst_hs", 32'(vga_hs), 32'd1);
        chk("mid_rst_vs", 32'(vga_vs), 32'd1);
        chk("mid_rst_blank", 32'(vga_blank), 32'd0);
        chk("mid_rst_rgb", 32'(vga_rgb), 32'd0);
        chk("mid_rst_lock", 32'(locked), 32'd0);
        for (int i = 0; i < 70; i++) cycle();

`ifdef VGA_STREAM_STATS_EN
        rst = 1;
        cycle();
        rst = 0;
        chk("cnt_rst", 32'(underflow_cnt), 32'd0);
        for (int k = 0; k < 3; k++) force_drop();
        cycle();
        chk("cnt_three", 32'(underflow_cnt), 32'd3);
`endif

        // random traffic with gaps and stray sof
        pv = 90; ps = 3;
        for (int i = 0; i < 400; i++) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_stream_timing.md
# vga_stream_timing

Parametrised single-clock VGA timing generator with a pixel-stream sink, successor to the fixed 800x480 controller. It produces HS/VS/BLANK with configurable porches and sync polarities, consumes a valid/ready pixel stream with start-of-frame marker, and locks the stream to the raster. It detects underflow and misaligned frames, then resynchronises on the next frame. It sits after the clock-domain-crossing FIFO, in the pixel clock domain, driving the display pins.

## Interface
- HDISP, 800, active pixels per line; VDISP, 480, active lines
- HFP 40, HPULSE 48, HBP 40; VFP 13, VPULSE 3, VBP 29: porch/sync widths (pixels / lines)
- PIX_W, 24, pixel width; HS_POL, 0 / VS_POL, 0: sync active level
- BG_COLOR, '0, RGB emitted in active region while unlocked
- pixel_clk  in  1  sole clock
- pixel_rst  in  1  synchronous, active-high reset
- pix_valid / pix_sof  in  1  stream pixel valid / first pixel of frame
- pix_data  in  PIX_W  stream pixel
- pix_ready  out  1  pixel accepted when pix_valid && pix_ready
- vga_clk  out  1  = pixel_clk; vga_hs, vga_vs  out  1  syncs
- vga_blank  out  1  high = active display pixel; vga_rgb  out  PIX_W
- pos_x  out  $clog2(HDISP); pos_y  out  $clog2(VDISP): coordinates of current output pixel
- frame_start  out  1  pulse with first active pixel output; locked  out  1; underflow  out  1 pulse
- underflow_cnt  out  16  (only with VGA_STREAM_STATS_EN)

## Operation
- H_TOTAL = HDISP+HFP+HPULSE+HBP, V_TOTAL likewise; hcnt 0..H_TOTAL-1, vcnt 0..V_TOTAL-1; vcnt increments when hcnt wraps, both wrap to 0.
- Line order: front porch, sync, back porch, active. Sync active when hcnt in [HFP, HFP+HPULSE) (vcnt likewise). Active = hcnt >= H_TOTAL-HDISP && vcnt >= V_TOTAL-VDISP.
- States: SEEK, ARMED, LOCKED.
  - SEEK: pix_ready=1 except when pix_valid && pix_sof; non-sof pixels discarded. Valid sof -> ARMED, sof pixel held (not consumed).
  - ARMED: pix_ready=0 until first active position of a frame (hcnt=H_TOTAL-HDISP, vcnt=V_TOTAL-VDISP); there ready=1, pixel consumed -> LOCKED.
  - LOCKED: pix_ready=1 exactly on active positions. Active with !pix_valid -> underflow pulse, BG_COLOR output, -> SEEK. Accepted pix_sof at any active position other than frame first -> underflow pulse, BG_COLOR, -> SEEK. Non-sof at frame first position -> same.
- locked = (state==LOCKED). Blanking RGB = 0; unlocked active RGB = BG_COLOR.

## Timing
- All video outputs registered: 1 cycle from counter position to vga_hs/vs/blank/rgb/pos/frame_start; all mutually aligned.
- pix_ready combinational from state and counters; the accepted pixel appears on vga_rgb next cycle.
- underflow pulse aligned with the BG_COLOR pixel it replaces.
- Reset: hcnt=vcnt=0, state SEEK, vga_hs=!HS_POL, vga_vs=!VS_POL, vga_blank=0, vga_rgb=0, pos 0, frame_start=0, underflow=0, pix_ready=0 while pixel_rst high. Reset mid-frame discards held sof pixel; raster restarts at 0.

## Configuration
- VGA_STREAM_STATS_EN defined: underflow_cnt port present, 16-bit saturating (holds 0xFFFF) count of underflow pulses, cleared by pixel_rst. Undefined: port and logic absent; all else identical.

## Structure
- Package vga_pkg: lock_state_t enum (SEEK, ARMED, LOCKED), default 800x480 timing constants, counter-width helpers.
- Sub-module vga_raster_cnt: h/v counters plus active/sync/first-pixel decodes; top holds FSM and output registers.

## Test plan
Bench params: HDISP=4, VDISP=2, all porches/pulses=1, PIX_W=8, BG_COLOR=8'hAA (H_TOTAL=7, V_TOTAL=5, frame 35 cycles).
- Reset release, no stream -> vga_hs low 1 of every 7 cycles, vga_vs low 7 of every 35, vga_blank high 8 cycles/frame with vga_rgb=8'hAA, locked=0.
- Continuous valid stream 0,1,2,... with sof on multiples of 8 -> locked within 2 frames; rgb 0..3 at pos_y=0, 4..7 at pos_y=1, pos_x 0..3; frame_start once per 35 cycles.
- Locked, pix_valid low at pixel 5 -> underflow pulse at that pixel, rgb 8'hAA for 5..7, locked=0, relock next frame.
- Locked, sof asserted on pixel 2 -> underflow, SEEK, relock on following frame with that sof pixel first.
- Reset asserted mid active line -> next cycle outputs at reset values, state SEEK, raster restarts at hcnt=0.
- With VGA_STREAM_STATS_EN: 3 forced underflows -> underflow_cnt=3; after reset -> 0.
